// File: rtl/star_box_reader.sv
// star_box_reader
//   Raster-scans the inclusive region [xLeft..xRight] x [yTop..yBottom] of a
//   pixel memory through a synchronous-read port. It classifies each pixel
//   as a star when rdData >= threshold (unsigned) and reports the bounding
//   box of all star pixels found.
//
// Ports
//   clk, resetn        clock (posedge) and synchronous active-low reset
//   start              begin a scan; sampled only in IDLE
//   xLeft..yBottom     search box, inclusive; latched when start is accepted
//   threshold          star threshold; latched when start is accepted
//   rdData             memory read data, valid the cycle after rdEn
//   xAddr, yAddr, rdEn memory read address and strobe
//   busy, done         scan in progress / one-cycle completion pulse
//   found, box*        star bounding box from the most recent scan
//   hitCount           number of star pixels (only with STAR_HIT_COUNT_EN)
//
// Optional feature macro: STAR_HIT_COUNT_EN adds the hitCount output.
module star_box_reader #(
  parameter int xSz   = 3,
  parameter int ySz   = 3,
  parameter int colSz = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [xSz-1:0]   xLeft,
  input  logic [xSz-1:0]   xRight,
  input  logic [ySz-1:0]   yTop,
  input  logic [ySz-1:0]   yBottom,
  input  logic [colSz-1:0] threshold,
  input  logic [colSz-1:0] rdData,
  output logic [xSz-1:0]   xAddr,
  output logic [ySz-1:0]   yAddr,
  output logic             rdEn,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [xSz-1:0]   boxLeft,
  output logic [xSz-1:0]   boxRight,
  output logic [ySz-1:0]   boxTop,
`ifdef STAR_HIT_COUNT_EN
  output logic [ySz-1:0]   boxBottom,
  output logic [xSz+ySz:0] hitCount
`else
  output logic [ySz-1:0]   boxBottom
`endif
);

  typedef enum logic [1:0] {IDLE, READ, EVAL, DONE} state_e;

  state_e           state_q, state_d;
  logic [xSz-1:0]   x_q, x_d;
  logic [ySz-1:0]   y_q, y_d;
  logic [xSz-1:0]   xl_q, xl_d;
  logic [xSz-1:0]   xr_q, xr_d;
  logic [ySz-1:0]   yb_q, yb_d;
  logic [colSz-1:0] thr_q, thr_d;
  logic             found_q, found_d;
  logic [xSz-1:0]   box_left_q, box_left_d;
  logic [xSz-1:0]   box_right_q, box_right_d;
  logic [ySz-1:0]   box_top_q, box_top_d;
  logic [ySz-1:0]   box_bottom_q, box_bottom_d;
`ifdef STAR_HIT_COUNT_EN
  logic [xSz+ySz:0] hit_cnt_q, hit_cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      xl_q         <= '0;
      xr_q         <= '0;
      yb_q         <= '0;
      thr_q        <= '0;
      found_q      <= 1'b0;
      box_left_q   <= '0;
      box_right_q  <= '0;
      box_top_q    <= '0;
      box_bottom_q <= '0;
`ifdef STAR_HIT_COUNT_EN
      hit_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xl_q         <= xl_d;
      xr_q         <= xr_d;
      yb_q         <= yb_d;
      thr_q        <= thr_d;
      found_q      <= found_d;
      box_left_q   <= box_left_d;
      box_right_q  <= box_right_d;
      box_top_q    <= box_top_d;
      box_bottom_q <= box_bottom_d;
`ifdef STAR_HIT_COUNT_EN
      hit_cnt_q    <= hit_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    xl_d         = xl_q;
    xr_d         = xr_q;
    yb_d         = yb_q;
    thr_d        = thr_q;
    found_d      = found_q;
    box_left_d   = box_left_q;
    box_right_d  = box_right_q;
    box_top_d    = box_top_q;
    box_bottom_d = box_bottom_q;
`ifdef STAR_HIT_COUNT_EN
    hit_cnt_d    = hit_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = READ;
          x_d          = xLeft;
          y_d          = yTop;
          xl_d         = xLeft;
          xr_d         = xRight;
          yb_d         = yBottom;
          thr_d        = threshold;
          found_d      = 1'b0;
          box_left_d   = '0;
          box_right_d  = '0;
          box_top_d    = '0;
          box_bottom_d = '0;
`ifdef STAR_HIT_COUNT_EN
          hit_cnt_d    = '0;
`endif
        end
      end
      READ: state_d = EVAL;
      EVAL: begin
        if (rdData >= thr_q) begin
`ifdef STAR_HIT_COUNT_EN
          hit_cnt_d = hit_cnt_q + 1'b1;
`endif
          if (!found_q) begin
            found_d      = 1'b1;
            box_left_d   = x_q;
            box_right_d  = x_q;
            box_top_d    = y_q;
            box_bottom_d = y_q;
          end else begin
            // Raster order: the first hit already fixed the top row, and
            // every later hit is on the same or a lower row.
            if (x_q < box_left_q)  box_left_d  = x_q;
            if (x_q > box_right_q) box_right_d = x_q;
            box_bottom_d = y_q;
          end
        end
        // Counters wrap at their width, so an inverted box still terminates.
        if (x_q != xr_q) begin
          x_d     = x_q + 1'b1;
          state_d = READ;
        end else if (y_q != yb_q) begin
          x_d     = xl_q;
          y_d     = y_q + 1'b1;
          state_d = READ;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign xAddr     = x_q;
  assign yAddr     = y_q;
  assign rdEn      = (state_q == READ);
  assign busy      = (state_q == READ) || (state_q == EVAL);
  assign done      = (state_q == DONE);
  assign found     = found_q;
  assign boxLeft   = box_left_q;
  assign boxRight  = box_right_q;
  assign boxTop    = box_top_q;
  assign boxBottom = box_bottom_q;
`ifdef STAR_HIT_COUNT_EN
  assign hitCount  = hit_cnt_q;
`endif

endmodule

// File: doc/star_box_reader.md
Name: star_box_reader

Overview:
- Raster-scans a rectangular region of pixel memory and reads each pixel through a synchronous-read port.
- Classifies every pixel as "star" when its colour is at or above a threshold.
- Reports the bounding box of all star pixels found in the region.
- Read-side counterpart of the box-clear writer: the detector supplies the box, the clear block erases it.

Parameters:
- xSz, 3, width of x coordinates.
- ySz, 3, width of y coordinates.
- colSz, 3, width of pixel colour data.

Ports:
- clk  input  1  clock; all logic on posedge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- xLeft  input  xSz  leftmost column of the search box, inclusive.
- xRight  input  xSz  rightmost column of the search box, inclusive.
- yTop  input  ySz  top row of the search box, inclusive.
- yBottom  input  ySz  bottom row of the search box, inclusive.
- threshold  input  colSz  unsigned star threshold.
- rdData  input  colSz  memory read data; valid the cycle after rdEn.
- xAddr  output  xSz  memory read column.
- yAddr  output  ySz  memory read row.
- rdEn  output  1  memory read strobe.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when results are final.
- found  output  1  at least one star pixel was seen in the last scan.
- boxLeft  output  xSz  bounding box of star pixels.
- boxRight  output  xSz  bounding box of star pixels.
- boxTop  output  ySz  bounding box of star pixels.
- boxBottom  output  ySz  bounding box of star pixels.

Behaviour:
- Reset values: all outputs 0; state IDLE; x/y counters 0.
- xLeft, xRight, yTop, yBottom and threshold are latched at start; input changes during a scan are ignored.
- FSM states: IDLE, READ, EVAL, DONE.
  - IDLE: when start=1, load x=xLeft, y=yTop, clear found and box registers to 0, go to READ. Otherwise stay.
  - READ: rdEn=1, xAddr=x, yAddr=y, busy=1, go to EVAL.
  - EVAL: busy=1; compare rdData against the latched threshold (hit when rdData >= threshold, unsigned), then:
    - x != latched xRight: x <= x+1, go to READ.
    - x == xRight and y != yBottom: x <= xLeft, y <= y+1, go to READ.
    - x == xRight and y == yBottom: go to DONE.
  - DONE: done=1, busy=0, go to IDLE.
- Bounding-box update on a hit in EVAL:
  - If found=0: found <= 1; boxLeft = boxRight = x; boxTop = boxBottom = y.
  - Otherwise: boxLeft <= min(boxLeft, x); boxRight <= max(boxRight, x); boxBottom <= y. boxTop is unchanged, since raster order guarantees the first hit is the top row.
- Latency: with W = xRight-xLeft+1 and H = yBottom-yTop+1, exactly 2·W·H cycles in READ/EVAL.
  - done is high in the cycle 2·W·H+1 after the edge that sampled start.
  - 1x1 box: done rises 3 cycles after start.
- xAddr/yAddr hold the current x/y counters in all states; rdEn is high only in READ.
- found and box outputs update only during a scan. They are final in DONE and held until the next start is accepted in IDLE.
- start while busy or in DONE: ignored, no restart.
- resetn=0 at any time, including mid-scan: next cycle is IDLE with all outputs 0; no done pulse.
- threshold=0: every pixel hits; the box equals the search box.
- xLeft > xRight (or yTop > yBottom) is illegal. Counters wrap modulo 2^xSz (2^ySz) until they match, so the scan always terminates.

Optional Feature:
- Macro: STAR_HIT_COUNT_EN.
- Defined:
  - Adds output hitCount, width xSz+ySz+1, reset 0.
  - Cleared when start is accepted; +1 per hit in EVAL; held after DONE like the box outputs.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- 8x8 memory all 0, box (0,7,0,7), threshold=1, start -> done pulse exactly 129 cycles after start, found=0, box outputs 0, exactly 64 rdEn pulses.
- Memory star pixels value 7 at (2,3),(5,3),(1,4),(4,6), box (0,7,0,7), threshold=4 -> found=1, boxLeft=1, boxRight=5, boxTop=3, boxBottom=6; hitCount=4 if STAR_HIT_COUNT_EN.
- Box (3,3,5,5), pixel (3,5)=5, threshold=5 -> done 3 cycles after start, found=1, all box outputs at 3/5; threshold=6 -> found=0.
- Pixel (6,1)=7 outside box (0,3,0,3), threshold=1 -> found=0; address trace stays within x 0..3, y 0..3 in raster order.
- Assert resetn=0 mid-scan after 10 cycles -> all outputs 0 next cycle, no done pulse; a new start then completes normally.
- Pulse start again during a scan, and change xRight mid-scan -> ignored; single done pulse at the originally computed cycle with the original bounds.
